// File: rtl/stopwatch_pkg.sv
// Shared definitions for the lap stopwatch: FSM encodings, BCD limits,
// time-word layout and a two-digit BCD increment helper.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2
    } sw_state_e;

    localparam logic [3:0] BCD_UNIT_MAX    = 4'd9;
    localparam logic [3:0] BCD_TEN_SEC_MAX = 4'd5;

    localparam int unsigned TIME_W   = 24;
    localparam int unsigned CSEC_LSB = 0;
    localparam int unsigned SEC_LSB  = 8;
    localparam int unsigned MIN_LSB  = 16;

    localparam logic [7:0] CSEC_LIM = {BCD_UNIT_MAX, BCD_UNIT_MAX};
    localparam logic [7:0] SEC_LIM  = {BCD_TEN_SEC_MAX, BCD_UNIT_MAX};

    // Returns {carry, next}; the pair wraps to 00 with carry when v equals lim.
    function automatic logic [8:0] bcd_step(input logic [7:0] v, input logic [7:0] lim);
        logic [8:0] r;
        if (v == lim) begin
            r = {1'b1, 8'h00};
        end else if (v[3:0] == BCD_UNIT_MAX) begin
            r = {1'b0, v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {1'b0, v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/sw_btn_edge.sv
// Async active-low push button: 2-FF synchroniser plus falling-edge detector.
// Flops reset to the pressed level so a button held through reset never fires.
module sw_btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n_i,
    output logic press_c
);

    logic [2:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], btn_n_i};
        end
    end

    assign press_c = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/lap_stopwatch.sv
// MM:SS.cc BCD stopwatch with start/stop/clear control and a circular
// lap memory read back newest-first through LapSel.
module lap_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ    = 50_000_000,
    parameter int unsigned LAP_DEPTH = 4,
    parameter int unsigned MAX_MIN   = 59,
    localparam int unsigned LW       = $clog2(LAP_DEPTH)
) (
    input  logic          Clk,
    input  logic          Rst,
    input  logic          fStart,
    input  logic          fStop,
    input  logic          fLap,
    input  logic [LW-1:0] LapSel,
    output logic [7:0]    oCSec,
    output logic [7:0]    oSec,
    output logic [7:0]    oMin,
    output logic          oRun,
    output logic          oWrap,
    output logic [LW:0]   oLapCnt,
    output logic [23:0]   oLapTime
);

    localparam int unsigned DIV = CLK_HZ / 100;
    localparam int unsigned DW  = $clog2(DIV);
    localparam logic [7:0]  MIN_LIM = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};

    logic start_p, stop_p, lap_p;

    sw_btn_edge u_btn_start (.clk(Clk), .rst_n(Rst), .btn_n_i(fStart), .press_c(start_p));
    sw_btn_edge u_btn_stop  (.clk(Clk), .rst_n(Rst), .btn_n_i(fStop),  .press_c(stop_p));
    sw_btn_edge u_btn_lap   (.clk(Clk), .rst_n(Rst), .btn_n_i(fLap),   .press_c(lap_p));

    sw_state_e         state_q, state_d;
    logic [DW-1:0]     div_q, div_d;
    logic [TIME_W-1:0] time_q, time_d;
    logic              wrap_q, wrap_d;
    logic              run_q;
    logic [LW-1:0]     wptr_q, wptr_d;
    logic [LW:0]       lcnt_q, lcnt_d;
    logic [TIME_W-1:0] laptime_q, laptime_d;
    logic [TIME_W-1:0] lap_mem_q [LAP_DEPTH];
    logic              lap_we;
    logic              tick;
    logic [LW-1:0]     rd_idx;

    logic       cs_cy, s_cy, m_cy;
    logic [7:0] cs_nx, s_nx, m_nx;

    assign {cs_cy, cs_nx} = bcd_step(time_q[CSEC_LSB +: 8], CSEC_LIM);
    assign {s_cy,  s_nx}  = bcd_step(time_q[SEC_LSB  +: 8], SEC_LIM);
    assign {m_cy,  m_nx}  = bcd_step(time_q[MIN_LSB  +: 8], MIN_LIM);

    // Next-state, divider, time ripple and lap-write control.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        time_d  = time_q;
        wrap_d  = 1'b0;
        wptr_d  = wptr_q;
        lcnt_d  = lcnt_q;
        lap_we  = 1'b0;
        tick    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start_p) begin
                    state_d = S_RUN;
                    div_d   = '0;
                end
            end
            S_RUN: begin
                tick  = (div_q == DW'(DIV - 1));
                div_d = tick ? '0 : div_q + DW'(1);
                if (tick) begin
                    time_d[CSEC_LSB +: 8] = cs_nx;
                    if (cs_cy) time_d[SEC_LSB +: 8] = s_nx;
                    if (cs_cy && s_cy) time_d[MIN_LSB +: 8] = m_nx;
                    wrap_d = cs_cy & s_cy & m_cy;
                end
                // Lap is taken before Stop is acted on, so both can land together.
                if (lap_p) begin
                    lap_we = 1'b1;
                    wptr_d = wptr_q + LW'(1);
                    if (lcnt_q != (LW+1)'(LAP_DEPTH)) lcnt_d = lcnt_q + (LW+1)'(1);
                end
                if (stop_p) state_d = S_PAUSE;
            end
            S_PAUSE: begin
                if (stop_p) begin
                    state_d = S_IDLE;
                    time_d  = '0;
                    div_d   = '0;
                    wptr_d  = '0;
                    lcnt_d  = '0;
                end else if (start_p) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign rd_idx = wptr_q - LW'(1) - LapSel;

    always_comb begin
        laptime_d = '0;
        if ({1'b0, LapSel} < lcnt_q) laptime_d = lap_mem_q[rd_idx];
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            time_q    <= '0;
            wrap_q    <= 1'b0;
            run_q     <= 1'b0;
            wptr_q    <= '0;
            lcnt_q    <= '0;
            laptime_q <= '0;
            for (int i = 0; i < LAP_DEPTH; i++) lap_mem_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            time_q    <= time_d;
            wrap_q    <= wrap_d;
            run_q     <= (state_d == S_RUN);
            wptr_q    <= wptr_d;
            lcnt_q    <= lcnt_d;
            laptime_q <= laptime_d;
            if (lap_we) lap_mem_q[wptr_q] <= time_q;
        end
    end

    assign oCSec    = time_q[CSEC_LSB +: 8];
    assign oSec     = time_q[SEC_LSB  +: 8];
    assign oMin     = time_q[MIN_LSB  +: 8];
    assign oRun     = run_q;
    assign oWrap    = wrap_q;
    assign oLapCnt  = lcnt_q;
    assign oLapTime = laptime_q;

endmodule

// File: tb/tb_lap_stopwatch.sv
// Directed bench for lap_stopwatch: a 10-cycle-tick instance for control and laps,
// and a 2-cycle-tick, 1-minute-wrap instance for the rollover corner.
module tb_lap_stopwatch;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       fStart, fStop, fLap;
    logic [1:0] LapSel;
    logic [7:0] oCSec, oSec, oMin;
    logic       oRun, oWrap;
    logic [2:0] oLapCnt;
    logic [23:0] oLapTime;

    logic       wStart;
    logic [7:0] w_csec, w_sec, w_min;
    logic       w_run, w_wrap;
    logic [2:0] w_lapcnt;
    logic [23:0] w_laptime;

    int n_cmp = 0;
    int n_mis = 0;

    typedef struct {
        logic [1:0]  sel;
        logic [23:0] exp;
    } lap_vec_t;

    lap_vec_t lap_tbl [4];

    always #10 Clk = ~Clk;

    lap_stopwatch #(.CLK_HZ(1000), .LAP_DEPTH(4), .MAX_MIN(59)) u_dut (
        .Clk(Clk), .Rst(Rst), .fStart(fStart), .fStop(fStop), .fLap(fLap),
        .LapSel(LapSel), .oCSec(oCSec), .oSec(oSec), .oMin(oMin), .oRun(oRun),
        .oWrap(oWrap), .oLapCnt(oLapCnt), .oLapTime(oLapTime)
    );

    lap_stopwatch #(.CLK_HZ(200), .LAP_DEPTH(4), .MAX_MIN(1)) u_wrap (
        .Clk(Clk), .Rst(Rst), .fStart(wStart), .fStop(1'b1), .fLap(1'b1),
        .LapSel(2'd0), .oCSec(w_csec), .oSec(w_sec), .oMin(w_min), .oRun(w_run),
        .oWrap(w_wrap), .oLapCnt(w_lapcnt), .oLapTime(w_laptime)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge Clk);
    endtask

    // m[0]=start, m[1]=stop, m[2]=lap; pins low for one clock period.
    task automatic press(input logic [2:0] m);
        if (m[0]) fStart = 1'b0;
        if (m[1]) fStop  = 1'b0;
        if (m[2]) fLap   = 1'b0;
        @(negedge Clk);
        fStart = 1'b1;
        fStop  = 1'b1;
        fLap   = 1'b1;
    endtask

    function automatic logic [31:0] tnow();
        return {8'h00, oMin, oSec, oCSec};
    endfunction

    function automatic logic [31:0] wnow();
        return {8'h00, w_min, w_sec, w_csec};
    endfunction

    initial begin
        lap_tbl[0] = '{sel: 2'd0, exp: 24'h000500};
        lap_tbl[1] = '{sel: 2'd1, exp: 24'h000400};
        lap_tbl[2] = '{sel: 2'd2, exp: 24'h000300};
        lap_tbl[3] = '{sel: 2'd3, exp: 24'h000200};

        Rst = 1'b0; fStart = 1'b1; fStop = 1'b1; fLap = 1'b1; wStart = 1'b1; LapSel = 2'd0;
        #25;
        chk("rst_time", tnow(), 32'h0);
        chk("rst_flags", {oRun, oWrap, oLapCnt, oLapTime}, 32'h0);
        @(negedge Clk);
        Rst = 1'b1;
        cyc(5);
        chk("idle_after_rst", {oRun, oLapCnt, tnow()}, 32'h0);

        // start, then 1.00 s of counting
        press(3'b001); cyc(2);
        chk("start_run", {31'h0, oRun}, 32'h1);
        chk("start_time0", tnow(), 32'h0);
        cyc(1000);
        chk("one_second", tnow(), 32'h000100);

        // stop freezes at 6.00; resume keeps the divider phase
        cyc(5000);
        chk("six_seconds", tnow(), 32'h000600);
        press(3'b010); cyc(2);
        chk("stop_run", {31'h0, oRun}, 32'h0);
        chk("stop_time", tnow(), 32'h000600);
        cyc(50);
        chk("paused_frozen", tnow(), 32'h000600);
        press(3'b001); cyc(2);
        chk("resume_run", {31'h0, oRun}, 32'h1);
        cyc(6);
        chk("resume_pre_tick", tnow(), 32'h000600);
        cyc(1);
        chk("resume_tick", tnow(), 32'h000601);
        press(3'b010); cyc(2);
        press(3'b010); cyc(2);
        chk("clear_time", tnow(), 32'h0);
        chk("clear_flags", {oRun, oLapCnt}, 32'h0);
        press(3'b010); cyc(2);
        press(3'b100); cyc(2);
        chk("idle_ignores", {oRun, oLapCnt}, 32'h0);

        // five laps at 1.00 s spacing, each holding k.00 s
        press(3'b001); cyc(2);
        for (int k = 1; k <= 5; k++) begin
            cyc(k == 1 ? 1002 : 997);
            press(3'b100); cyc(2);
            chk($sformatf("lapcnt_%0d", k), {29'h0, oLapCnt}, (k < 4) ? k : 4);
        end
        for (int i = 0; i < 4; i++) begin
            LapSel = lap_tbl[i].sel;
            cyc(1);
            chk($sformatf("lap_sel%0d", i), {8'h00, oLapTime}, {8'h00, lap_tbl[i].exp});
        end
        press(3'b001); cyc(2);
        chk("run_ignores_start", {31'h0, oRun}, 32'h1);
        press(3'b010); cyc(2);
        press(3'b010); cyc(2);
        LapSel = 2'd0;
        cyc(1);
        chk("clear_lapcnt", {29'h0, oLapCnt}, 32'h0);
        chk("clear_laptime", {8'h00, oLapTime}, 32'h0);

        // rollover on the 1-minute instance
        wStart = 1'b0; @(negedge Clk); wStart = 1'b1; cyc(2);
        chk("w_run", {31'h0, w_run}, 32'h1);
        cyc(23998);
        chk("w_max", wnow(), 32'h015999);
        chk("w_nowrap", {31'h0, w_wrap}, 32'h0);
        cyc(1);
        chk("w_max_hold", wnow(), 32'h015999);
        cyc(1);
        chk("w_wrapped", wnow(), 32'h0);
        chk("w_wrap_flags", {30'h0, w_wrap, w_run}, 32'h3);
        cyc(1);
        chk("w_wrap_1cyc", {30'h0, w_wrap, w_run}, 32'h1);
        cyc(1);
        chk("w_after_wrap", wnow(), 32'h000001);

        // simultaneous stop+start, lap ignored in pause, then lap+stop
        press(3'b001); cyc(2);
        cyc(298);
        press(3'b011); cyc(2);
        chk("stop_beats_start", {31'h0, oRun}, 32'h0);
        chk("stop_start_time", tnow(), 32'h000030);
        cyc(10);
        chk("pause_hold", tnow(), 32'h000030);
        press(3'b100); cyc(2);
        chk("pause_ignores_lap", {29'h0, oLapCnt}, 32'h0);
        press(3'b001); cyc(2);
        cyc(20);
        press(3'b110); cyc(2);
        chk("lapstop_run", {31'h0, oRun}, 32'h0);
        chk("lapstop_cnt", {29'h0, oLapCnt}, 32'h1);
        chk("lapstop_time", tnow(), 32'h000032);
        cyc(1);
        chk("lapstop_lap", {8'h00, oLapTime}, 32'h000032);
        LapSel = 2'd1;
        cyc(1);
        chk("lap_invalid_sel", {8'h00, oLapTime}, 32'h0);
        LapSel = 2'd0;
        cyc(1);

        // async reset mid-run with a held start button
        press(3'b001); cyc(2);
        cyc(30);
        chk("pre_reset_run", {31'h0, oRun}, 32'h1);
        fStart = 1'b0;
        #5;
        Rst = 1'b0;
        #1;
        chk("async_rst_time", tnow(), 32'h0);
        chk("async_rst_flags", {oRun, oWrap, oLapCnt, oLapTime}, 32'h0);
        chk("async_rst_w", {w_run, w_lapcnt, w_laptime}, 32'h0);
        @(negedge Clk);
        Rst = 1'b1;
        cyc(10);
        chk("held_no_event", {31'h0, oRun}, 32'h0);
        fStart = 1'b1;
        cyc(3);
        press(3'b001); cyc(2);
        chk("restart_after_rst", {31'h0, oRun}, 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
